cpu_sramlike_adapter: RTL and testbench

CPU-side adapter sitting directly upstream of the AXI bridge. It converts the pipeline's SRAM-style inst/data ports (enable + address, one-cycle expectation) into sram-like request/addr_ok/data_ok transactions. It generates per-port stall signals and buffers returned data until the pipeline advances. It also drops responses of requests killed by a pipeline flush.

---
 rtl/cpu_sramlike_pkg.sv | 16 +
 rtl/sramlike_port_ctrl.sv | 70 +++++++
 rtl/cpu_sramlike_adapter.sv | 85 ++++++++
 tb/tb_cpu_sramlike_adapter.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_sramlike_pkg.sv
// Shared types and constants for the CPU-side sram-like adapter.
package cpu_sramlike_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    DONE,
    DROP
  } port_state_t;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

endpackage

// File: rtl/sramlike_port_ctrl.sv
// One sram-like port: request FSM, returned-data buffer and pipeline stall.
module sramlike_port_ctrl
  import cpu_sramlike_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        en,
  input  logic        flush,
  input  logic        longest_stall,
  input  logic        addr_ok,
  input  logic        data_ok,
  input  logic [31:0] rdata_in,
  output logic        req,
  output logic        stall,
  output logic [31:0] rdata
);

  port_state_t state;
  logic [31:0] rdata_buf;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      rdata_buf <= 32'h0;
    end else begin
      case (state)
        IDLE: if (en && !flush) state <= addr_ok ? WAIT : REQ;
        REQ: begin
          if (flush)        state <= addr_ok ? DROP : IDLE;
          else if (addr_ok) state <= WAIT;
        end
        WAIT: begin
          if (data_ok) begin
            rdata_buf <= rdata_in;
            state     <= (longest_stall && !flush) ? DONE : IDLE;
          end else if (flush) begin
            state <= DROP;
          end
        end
        DONE: if (!longest_stall || flush) state <= IDLE;
        DROP: if (data_ok) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // req is gated by reset so an in-reset pipeline never presents a request.
  always_comb begin
    req   = 1'b0;
    stall = 1'b0;
    rdata = rdata_buf;
    case (state)
      IDLE: begin
        req   = resetn && en && !flush;
        stall = en;
      end
      REQ: begin
        req   = resetn;
        stall = en;
      end
      WAIT: begin
        stall = en && !data_ok;
        if (data_ok) rdata = rdata_in;
      end
      DROP:    stall = en;
      default: stall = 1'b0;
    endcase
  end

endmodule

// File: rtl/cpu_sramlike_adapter.sv
// Converts the pipeline's SRAM-style inst/data ports into sram-like transactions.
module cpu_sramlike_adapter
  import cpu_sramlike_pkg::*;
#(
  parameter logic [1:0] INST_SIZE = SIZE_WORD
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        longest_stall,
  input  logic        flush,

  input  logic        inst_sram_en,
  input  logic [31:0] inst_sram_addr,
  output logic [31:0] inst_sram_rdata,
  output logic        i_stall,

  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_wen,
  input  logic [1:0]  data_sram_size,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  output logic        d_stall,

  output logic        inst_req,
  output logic        inst_wr,
  output logic [1:0]  inst_size,
  output logic [31:0] inst_addr,
  output logic [31:0] inst_wdata,
  input  logic [31:0] inst_rdata,
  input  logic        inst_addr_ok,
  input  logic        inst_data_ok,

  output logic        data_req,
  output logic        data_wr,
  output logic [1:0]  data_size,
  output logic [3:0]  data_wen,
  output logic [31:0] data_addr,
  output logic [31:0] data_wdata,
  input  logic [31:0] data_rdata,
  input  logic        data_addr_ok,
  input  logic        data_data_ok
);

  sramlike_port_ctrl u_inst (
    .clk           (clk),
    .resetn        (resetn),
    .en            (inst_sram_en),
    .flush         (flush),
    .longest_stall (longest_stall),
    .addr_ok       (inst_addr_ok),
    .data_ok       (inst_data_ok),
    .rdata_in      (inst_rdata),
    .req           (inst_req),
    .stall         (i_stall),
    .rdata         (inst_sram_rdata)
  );

  sramlike_port_ctrl u_data (
    .clk           (clk),
    .resetn        (resetn),
    .en            (data_sram_en),
    .flush         (flush),
    .longest_stall (longest_stall),
    .addr_ok       (data_addr_ok),
    .data_ok       (data_data_ok),
    .rdata_in      (data_rdata),
    .req           (data_req),
    .stall         (d_stall),
    .rdata         (data_sram_rdata)
  );

  // CPU holds address/data stable while stalled, so these pass straight through.
  assign inst_wr    = 1'b0;
  assign inst_size  = INST_SIZE;
  assign inst_addr  = inst_sram_addr;
  assign inst_wdata = 32'h0;

  assign data_wr    = |data_sram_wen;
  assign data_size  = data_sram_size;
  assign data_wen   = data_sram_wen;
  assign data_addr  = data_sram_addr;
  assign data_wdata = data_sram_wdata;

endmodule

// File: tb/tb_cpu_sramlike_adapter.sv
// Directed checks of the sram-like adapter with a hand-driven bridge.
module tb_cpu_sramlike_adapter;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        longest_stall = 1'b0;
  logic        flush = 1'b0;
  logic        inst_sram_en = 1'b0;
  logic [31:0] inst_sram_addr = 32'h0;
  logic [31:0] inst_sram_rdata;
  logic        i_stall;
  logic        data_sram_en = 1'b0;
  logic [3:0]  data_sram_wen = 4'h0;
  logic [1:0]  data_sram_size = 2'd0;
  logic [31:0] data_sram_addr = 32'h0;
  logic [31:0] data_sram_wdata = 32'h0;
  logic [31:0] data_sram_rdata;
  logic        d_stall;
  logic        inst_req, inst_wr;
  logic [1:0]  inst_size;
  logic [31:0] inst_addr, inst_wdata;
  logic [31:0] inst_rdata = 32'h0;
  logic        inst_addr_ok = 1'b0;
  logic        inst_data_ok = 1'b0;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [3:0]  data_wen;
  logic [31:0] data_addr, data_wdata;
  logic [31:0] data_rdata = 32'h0;
  logic        data_addr_ok = 1'b0;
  logic        data_data_ok = 1'b0;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  cpu_sramlike_adapter dut (
    .clk(clk), .resetn(resetn), .longest_stall(longest_stall), .flush(flush),
    .inst_sram_en(inst_sram_en), .inst_sram_addr(inst_sram_addr),
    .inst_sram_rdata(inst_sram_rdata), .i_stall(i_stall),
    .data_sram_en(data_sram_en), .data_sram_wen(data_sram_wen),
    .data_sram_size(data_sram_size), .data_sram_addr(data_sram_addr),
    .data_sram_wdata(data_sram_wdata), .data_sram_rdata(data_sram_rdata),
    .d_stall(d_stall),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
    .inst_addr(inst_addr), .inst_wdata(inst_wdata), .inst_rdata(inst_rdata),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_wen(data_wen), .data_addr(data_addr), .data_wdata(data_wdata),
    .data_rdata(data_rdata), .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; checks follow 1 unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // reset state
    #2;
    chk("rst_ireq", inst_req, 0);
    chk("rst_dreq", data_req, 0);
    chk("rst_istall", i_stall, 0);
    chk("rst_dstall", d_stall, 0);
    chk("rst_irdata", inst_sram_rdata, 0);
    chk("rst_drdata", data_sram_rdata, 0);
    tick(); resetn = 1'b1;

    // fetch: same-cycle addr_ok, data_ok after two wait cycles
    tick(); inst_sram_en = 1; inst_sram_addr = 32'hBFC00000; inst_addr_ok = 1; #1;
    chk("f1_req", inst_req, 1);
    chk("f1_addr", inst_addr, 32'hBFC00000);
    chk("f1_size", inst_size, 2);
    chk("f1_wr", {inst_wr, inst_wdata}, 0);
    chk("f1_stall0", i_stall, 1);
    tick(); inst_addr_ok = 0; #1;
    chk("f1_req_off", inst_req, 0);
    chk("f1_stall1", i_stall, 1);
    tick(); #1;
    chk("f1_stall2", i_stall, 1);
    tick(); inst_data_ok = 1; inst_rdata = 32'h3C1D0001; #1;
    chk("f1_stall_dok", i_stall, 0);
    chk("f1_rdata_dok", inst_sram_rdata, 32'h3C1D0001);
    tick(); inst_data_ok = 0; inst_rdata = 32'hFFFFFFFF; inst_sram_en = 0; #1;
    chk("f1_rdata_buf", inst_sram_rdata, 32'h3C1D0001);
    chk("f1_idle_req", inst_req, 0);

    // load completing while the pipeline is held
    tick(); data_sram_en = 1; data_sram_wen = 0; data_sram_size = 2;
    data_sram_addr = 32'h80000000; data_addr_ok = 1; #1;
    chk("ld_req", data_req, 1);
    chk("ld_wr", data_wr, 0);
    chk("ld_stall", d_stall, 1);
    tick(); data_addr_ok = 0; data_data_ok = 1; data_rdata = 32'h12345678; longest_stall = 1; #1;
    chk("ld_stall_dok", d_stall, 0);
    chk("ld_rdata_dok", data_sram_rdata, 32'h12345678);
    tick(); data_data_ok = 0; data_rdata = 32'hDEADBEEF; #1;
    chk("ld_done1_rdata", data_sram_rdata, 32'h12345678);
    chk("ld_done1_req", data_req, 0);
    chk("ld_done1_stall", d_stall, 0);
    tick(); #1;
    chk("ld_done2_rdata", data_sram_rdata, 32'h12345678);
    chk("ld_done2_req", data_req, 0);
    tick(); longest_stall = 0; #1;
    chk("ld_done3_rdata", data_sram_rdata, 32'h12345678);
    chk("ld_done3_req", data_req, 0);
    tick(); data_sram_en = 0; #1;
    chk("ld_idle_req", data_req, 0);

    // store with addr_ok arriving in the fourth request cycle
    tick(); data_sram_en = 1; data_sram_wen = 4'b0011; data_sram_size = 1;
    data_sram_addr = 32'h80000004; data_sram_wdata = 32'hAABBCCDD; #1;
    chk("st_req1", data_req, 1);
    chk("st_wr", data_wr, 1);
    chk("st_size", data_size, 1);
    chk("st_wen", data_wen, 4'b0011);
    chk("st_addr", data_addr, 32'h80000004);
    chk("st_wdata", data_wdata, 32'hAABBCCDD);
    tick(); #1; chk("st_req2", data_req, 1);
    tick(); #1; chk("st_req3", data_req, 1);
    tick(); data_addr_ok = 1; #1; chk("st_req4", data_req, 1);
    tick(); data_addr_ok = 0; #1;
    chk("st_one_req", data_req, 0);
    chk("st_wait_stall", d_stall, 1);
    tick(); data_data_ok = 1; data_rdata = 32'h0; #1;
    chk("st_stall_dok", d_stall, 0);
    tick(); data_data_ok = 0; data_sram_en = 0; data_sram_wen = 0; #1;

    // flush while waiting for data: response must be dropped
    tick(); inst_sram_en = 1; inst_sram_addr = 32'hBFC00380; inst_addr_ok = 1; #1;
    chk("fw_req", inst_req, 1);
    tick(); inst_addr_ok = 0; flush = 1; #1;
    chk("fw_flush_req", inst_req, 0);
    tick(); flush = 0; #1;
    chk("fw_drop_req", inst_req, 0);
    chk("fw_drop_stall", i_stall, 1);
    tick(); inst_data_ok = 1; inst_rdata = 32'hBADBAD00; #1;
    chk("fw_drop_rdata", inst_sram_rdata, 32'h3C1D0001);
    chk("fw_drop_stall_dok", i_stall, 1);
    chk("fw_drop_req_dok", inst_req, 0);
    tick(); inst_data_ok = 0; #1;
    chk("fw_new_req", inst_req, 1);
    chk("fw_buf_kept", inst_sram_rdata, 32'h3C1D0001);

    // flush in REQ without addr_ok: withdraw
    tick(); flush = 1; #1;
    chk("fr_req_held", inst_req, 1);
    tick(); flush = 0; inst_sram_en = 0; #1;
    chk("fr_req_gone", inst_req, 0);
    chk("fr_stall_gone", i_stall, 0);

    // flush in IDLE with en high issues nothing
    tick(); inst_sram_en = 1; flush = 1; #1;
    chk("fi_no_req", inst_req, 0);

    // flush coinciding with addr_ok in REQ: drop
    tick(); flush = 0; #1;
    chk("fa_req1", inst_req, 1);
    tick(); flush = 1; inst_addr_ok = 1; #1;
    chk("fa_req2", inst_req, 1);
    tick(); flush = 0; inst_addr_ok = 0; #1;
    chk("fa_drop_req", inst_req, 0);
    chk("fa_drop_stall", i_stall, 1);
    tick(); inst_data_ok = 1; inst_rdata = 32'h11111111; #1;
    chk("fa_drop_rdata", inst_sram_rdata, 32'h3C1D0001);
    tick(); inst_data_ok = 0; inst_sram_en = 0; #1;
    chk("fa_idle_req", inst_req, 0);

    // asynchronous reset mid-WAIT on both ports
    tick(); inst_sram_en = 1; inst_sram_addr = 32'hBFC00000; inst_addr_ok = 1;
    data_sram_en = 1; data_sram_addr = 32'h80000010; data_addr_ok = 1; #1;
    chk("ar_ireq", inst_req, 1);
    chk("ar_dreq", data_req, 1);
    tick(); inst_addr_ok = 0; data_addr_ok = 0; #1;
    chk("ar_wait_ireq", inst_req, 0);
    #2; resetn = 0; #1;
    chk("ar_rst_ireq", inst_req, 0);
    chk("ar_rst_dreq", data_req, 0);
    chk("ar_rst_istall", i_stall, 1);
    chk("ar_rst_dstall", d_stall, 1);
    chk("ar_rst_irdata", inst_sram_rdata, 0);
    chk("ar_rst_drdata", data_sram_rdata, 32'h0);
    inst_sram_en = 0; data_sram_en = 0; #1;
    chk("ar_rst_istall_off", i_stall, 0);
    chk("ar_rst_dstall_off", d_stall, 0);
    tick(); resetn = 1;
    tick(); inst_sram_en = 1; inst_sram_addr = 32'hBFC00000; inst_addr_ok = 1; #1;
    chk("ar_post_req", inst_req, 1);
    tick(); inst_addr_ok = 0; #1;
    chk("ar_post_stall", i_stall, 1);
    tick(); inst_data_ok = 1; inst_rdata = 32'h3C1D0001; #1;
    chk("ar_post_stall_dok", i_stall, 0);
    chk("ar_post_rdata", inst_sram_rdata, 32'h3C1D0001);
    tick(); inst_data_ok = 0; inst_sram_en = 0; #1;
    chk("ar_post_buf", inst_sram_rdata, 32'h3C1D0001);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: observed no end expected end");
    $fatal(1, "timeout");
  end

endmodule
